// File: rtl/pipeline_controller_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller:
// FSM states, forwarding selects and the per-frame control bundle.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_FLUSH    = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Wide enough for FLUSH_CYCLES in 0..3.
    localparam int FLUSHCNT_WIDTH = 2;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
    } ctrl_bus_t;

    localparam ctrl_bus_t CTRL_ADVANCE = '{
        pc_we:       1'b1,
        ifid_we:     1'b1,
        ifid_flush:  1'b0,
        idex_we:     1'b1,
        idex_bubble: 1'b0,
        exmem_we:    1'b1,
        memwb_we:    1'b1
    };

    localparam ctrl_bus_t CTRL_HOLD = '0;

endpackage

// File: rtl/pipeline_controller_forward_unit.sv
// Combinational EX-operand forwarding comparator; one instance per operand.
// The EX/MEM result is newer than MEM/WB, so it wins when both match.
module forward_unit
    import pipeline_controller_pkg::*;
#(
    parameter int REGADDR_WIDTH = 5
) (
    input  logic [REGADDR_WIDTH-1:0] i_ex_loc,
    input  logic [REGADDR_WIDTH-1:0] i_mem_write_select,
    input  logic                     i_mem_write_enable,
    input  logic [REGADDR_WIDTH-1:0] i_wb_write_select,
    input  logic                     i_wb_write_enable,
    output logic [1:0]               o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hard-wired zero and is never a forwarding source.
    assign w_mem_hit = i_mem_write_enable && (i_mem_write_select != '0)
                       && (i_mem_write_select == i_ex_loc);
    assign w_wb_hit  = i_wb_write_enable && (i_wb_write_select != '0)
                       && (i_wb_write_select == i_ex_loc);

    always_comb begin
        o_sel = FWD_REG;
        if (w_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the IF/ID, ID/EX, EX/MEM, MEM/WB frames
// and the PC: write enables, bubbles, fetch flushes and EX forwarding selects.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int REGADDR_WIDTH  = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int STALLCNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REGADDR_WIDTH-1:0]  id_aLoc,
    input  logic                      id_aUsed,
    input  logic [REGADDR_WIDTH-1:0]  id_bLoc,
    input  logic                      id_bUsed,
    input  logic [REGADDR_WIDTH-1:0]  ex_aLoc,
    input  logic [REGADDR_WIDTH-1:0]  ex_bLoc,
    input  logic                      ex_load,
    input  logic [REGADDR_WIDTH-1:0]  ex_writeSelect,
    input  logic                      ex_writeEnable,
    input  logic [REGADDR_WIDTH-1:0]  mem_writeSelect,
    input  logic                      mem_writeEnable,
    input  logic [REGADDR_WIDTH-1:0]  wb_writeSelect,
    input  logic                      wb_writeEnable,
    input  logic                      branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_we,
    output logic                      ifid_we,
    output logic                      ifid_flush,
    output logic                      idex_we,
    output logic                      idex_bubble,
    output logic                      exmem_we,
    output logic                      memwb_we,
    output logic [1:0]                fwdA_sel,
    output logic [1:0]                fwdB_sel,
    output logic [STALLCNT_WIDTH-1:0] stall_cycles,
    output logic [1:0]                ctrl_state
);

    localparam logic [FLUSHCNT_WIDTH-1:0] FLUSH_LOAD = FLUSHCNT_WIDTH'(FLUSH_CYCLES);
    localparam logic [STALLCNT_WIDTH-1:0] STALL_MAX  = '1;

    ctrl_state_e               r_state;
    ctrl_state_e               w_state_nxt;
    logic [FLUSHCNT_WIDTH-1:0] r_flush_cnt;
    logic [FLUSHCNT_WIDTH-1:0] w_flush_cnt_nxt;
    logic [STALLCNT_WIDTH-1:0] r_stall_cycles;

    ctrl_bus_t  w_ctrl;
    ctrl_bus_t  w_ctrl_out;
    logic       w_freeze;
    logic       w_hazard_a;
    logic       w_hazard_b;
    logic       w_load_use;
    logic       w_stall_tick;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_freeze   = mem_req && !mem_ready;
    assign w_hazard_a = id_aUsed && (id_aLoc == ex_writeSelect);
    assign w_hazard_b = id_bUsed && (id_bLoc == ex_writeSelect);
    assign w_load_use = ex_load && ex_writeEnable && (ex_writeSelect != '0)
                        && id_valid && (w_hazard_a || w_hazard_b);

    // Priority: memory freeze, then taken branch, then load-use.
    always_comb begin
        w_ctrl          = CTRL_ADVANCE;
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (w_freeze) begin
            w_ctrl      = CTRL_HOLD;
            w_state_nxt = CTRL_MEM_WAIT;
        end else if (branch_taken) begin
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_bubble = 1'b1;
            w_flush_cnt_nxt    = FLUSH_LOAD;
            w_state_nxt        = (FLUSH_LOAD != '0) ? CTRL_FLUSH : CTRL_RUN;
        end else begin
            case (r_state)
                CTRL_RUN: begin
                    if (w_load_use) begin
                        w_ctrl.pc_we       = 1'b0;
                        w_ctrl.ifid_we     = 1'b0;
                        w_ctrl.idex_bubble = 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    w_ctrl.ifid_flush = 1'b1;
                    if (w_load_use) begin
                        w_ctrl.pc_we       = 1'b0;
                        w_ctrl.ifid_we     = 1'b0;
                        w_ctrl.idex_bubble = 1'b1;
                    end
                    w_flush_cnt_nxt = (r_flush_cnt != '0) ? r_flush_cnt - 1'b1 : '0;
                    w_state_nxt     = (r_flush_cnt > 2'd1) ? CTRL_FLUSH : CTRL_RUN;
                end
                CTRL_MEM_WAIT: begin
                    // Memory completed: resume any squash window that was interrupted.
                    w_state_nxt = (r_flush_cnt != '0) ? CTRL_FLUSH : CTRL_RUN;
                end
                default: begin
                    w_state_nxt = CTRL_RUN;
                end
            endcase
        end
        if (!(r_state inside {CTRL_RUN, CTRL_MEM_WAIT, CTRL_FLUSH})) begin
            w_state_nxt     = CTRL_RUN;
            w_flush_cnt_nxt = '0;
        end
    end

    assign w_ctrl_out   = reset ? CTRL_HOLD : w_ctrl;
    assign w_stall_tick = !w_ctrl_out.pc_we || w_ctrl_out.ifid_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= CTRL_RUN;
            r_flush_cnt    <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_stall_tick && (r_stall_cycles != STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + STALLCNT_WIDTH'(1);
            end
        end
    end

    forward_unit #(
        .REGADDR_WIDTH(REGADDR_WIDTH)
    ) u_fwd_a (
        .i_ex_loc          (ex_aLoc),
        .i_mem_write_select(mem_writeSelect),
        .i_mem_write_enable(mem_writeEnable),
        .i_wb_write_select (wb_writeSelect),
        .i_wb_write_enable (wb_writeEnable),
        .o_sel             (w_fwd_a)
    );

    forward_unit #(
        .REGADDR_WIDTH(REGADDR_WIDTH)
    ) u_fwd_b (
        .i_ex_loc          (ex_bLoc),
        .i_mem_write_select(mem_writeSelect),
        .i_mem_write_enable(mem_writeEnable),
        .i_wb_write_select (wb_writeSelect),
        .i_wb_write_enable (wb_writeEnable),
        .o_sel             (w_fwd_b)
    );

    assign pc_we        = w_ctrl_out.pc_we;
    assign ifid_we      = w_ctrl_out.ifid_we;
    assign ifid_flush   = w_ctrl_out.ifid_flush;
    assign idex_we      = w_ctrl_out.idex_we;
    assign idex_bubble  = w_ctrl_out.idex_bubble;
    assign exmem_we     = w_ctrl_out.exmem_we;
    assign memwb_we     = w_ctrl_out.memwb_we;
    assign fwdA_sel     = reset ? FWD_REG : w_fwd_a;
    assign fwdB_sel     = reset ? FWD_REG : w_fwd_b;
    assign stall_cycles = r_stall_cycles;
    assign ctrl_state   = r_state;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: inputs change on the falling edge,
// outputs are checked 1ns later, state updates land on the rising edge.
module tb_pipeline_controller;

    localparam int RW = 5;
    localparam int SW = 16;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1101011;
    localparam logic [6:0] C_LU   = 7'b0001111;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_FL   = 7'b1111011;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_aLoc;
    logic          id_aUsed;
    logic [RW-1:0] id_bLoc;
    logic          id_bUsed;
    logic [RW-1:0] ex_aLoc;
    logic [RW-1:0] ex_bLoc;
    logic          ex_load;
    logic [RW-1:0] ex_writeSelect;
    logic          ex_writeEnable;
    logic [RW-1:0] mem_writeSelect;
    logic          mem_writeEnable;
    logic [RW-1:0] wb_writeSelect;
    logic          wb_writeEnable;
    logic          branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
    logic [1:0]    fwdA_sel;
    logic [1:0]    fwdB_sel;
    logic [SW-1:0] stall_cycles;
    logic [1:0]    ctrl_state;
    logic [6:0]    ctrl_vec;

    int n_cmp = 0;
    int n_mis = 0;

    assign ctrl_vec = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we};

    pipeline_controller #(
        .REGADDR_WIDTH (RW),
        .FLUSH_CYCLES  (1),
        .STALLCNT_WIDTH(SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_aLoc        (id_aLoc),
        .id_aUsed       (id_aUsed),
        .id_bLoc        (id_bLoc),
        .id_bUsed       (id_bUsed),
        .ex_aLoc        (ex_aLoc),
        .ex_bLoc        (ex_bLoc),
        .ex_load        (ex_load),
        .ex_writeSelect (ex_writeSelect),
        .ex_writeEnable (ex_writeEnable),
        .mem_writeSelect(mem_writeSelect),
        .mem_writeEnable(mem_writeEnable),
        .wb_writeSelect (wb_writeSelect),
        .wb_writeEnable (wb_writeEnable),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_we        (idex_we),
        .idex_bubble    (idex_bubble),
        .exmem_we       (exmem_we),
        .memwb_we       (memwb_we),
        .fwdA_sel       (fwdA_sel),
        .fwdB_sel       (fwdB_sel),
        .stall_cycles   (stall_cycles),
        .ctrl_state     (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b1;  id_aLoc = '0; id_aUsed = 1'b0; id_bLoc = '0; id_bUsed = 1'b0;
        ex_aLoc = '0;     ex_bLoc = '0; ex_load = 1'b0;
        ex_writeSelect = '0;  ex_writeEnable = 1'b0;
        mem_writeSelect = '0; mem_writeEnable = 1'b0;
        wb_writeSelect = '0;  wb_writeEnable = 1'b0;
        branch_taken = 1'b0;  mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_use_x5();
        ex_load = 1'b1; ex_writeEnable = 1'b1; ex_writeSelect = 5'd5;
        id_valid = 1'b1; id_aUsed = 1'b1; id_aLoc = 5'd5;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl_vec), 32'(C_ZERO));
        check("reset_state", 32'(ctrl_state), 32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_fwdA", 32'(fwdA_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("run_default", 32'(ctrl_vec), 32'(C_RUN));

        // Load-use on source A.
        next_cycle();
        load_use_x5();
        #1;
        check("lu_a_ctrl", 32'(ctrl_vec), 32'(C_LU));
        next_cycle();
        idle();
        #1;
        check("lu_a_after", 32'(ctrl_vec), 32'(C_RUN));
        check("lu_a_state", 32'(ctrl_state), 32'd0);
        check("lu_a_stall", 32'(stall_cycles), 32'd1);

        // Destination x0 never stalls.
        next_cycle();
        load_use_x5();
        ex_writeSelect = 5'd0; id_aLoc = 5'd0;
        #1;
        check("lu_x0", 32'(ctrl_vec), 32'(C_RUN));

        // Invalid decode slot never stalls.
        next_cycle();
        load_use_x5();
        id_valid = 1'b0;
        #1;
        check("lu_invalid", 32'(ctrl_vec), 32'(C_RUN));

        // Load-use on source B only.
        next_cycle();
        idle();
        ex_load = 1'b1; ex_writeEnable = 1'b1; ex_writeSelect = 5'd9;
        id_bUsed = 1'b1; id_bLoc = 5'd9; id_aLoc = 5'd9;
        #1;
        check("lu_b_ctrl", 32'(ctrl_vec), 32'(C_LU));
        next_cycle();
        idle();
        #1;
        check("lu_b_stall", 32'(stall_cycles), 32'd2);

        // Taken branch with one squash cycle.
        branch_taken = 1'b1;
        #1;
        check("br_c0", 32'(ctrl_vec), 32'(C_BR));
        next_cycle();
        idle();
        #1;
        check("br_c1_state", 32'(ctrl_state), 32'd2);
        check("br_c1_ctrl", 32'(ctrl_vec), 32'(C_FL));
        next_cycle();
        #1;
        check("br_c2_state", 32'(ctrl_state), 32'd0);
        check("br_c2_ctrl", 32'(ctrl_vec), 32'(C_RUN));
        check("br_stall", 32'(stall_cycles), 32'd4);

        // Freeze dominates a pending branch and load-use.
        next_cycle();
        load_use_x5();
        branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("frz_c0_ctrl", 32'(ctrl_vec), 32'(C_ZERO));
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            #1;
            check("frz_ctrl", 32'(ctrl_vec), 32'(C_ZERO));
            check("frz_state", 32'(ctrl_state), 32'd1);
        end
        next_cycle();
        mem_ready = 1'b1;
        #1;
        check("frz_release_br", 32'(ctrl_vec), 32'(C_BR));
        next_cycle();
        idle();
        #1;
        check("frz_flush_state", 32'(ctrl_state), 32'd2);
        check("frz_flush_ctrl", 32'(ctrl_vec), 32'(C_FL));
        next_cycle();
        #1;
        check("frz_run_state", 32'(ctrl_state), 32'd0);
        check("frz_stall", 32'(stall_cycles), 32'd9);

        // A freeze inside FLUSH keeps the squash window pending.
        branch_taken = 1'b1;
        next_cycle();
        idle();
        mem_req = 1'b1;
        #1;
        check("fl_frz_ctrl", 32'(ctrl_vec), 32'(C_ZERO));
        next_cycle();
        mem_ready = 1'b1;
        #1;
        check("fl_wait_state", 32'(ctrl_state), 32'd1);
        check("fl_wait_ctrl", 32'(ctrl_vec), 32'(C_RUN));
        next_cycle();
        idle();
        #1;
        check("fl_resume_state", 32'(ctrl_state), 32'd2);
        check("fl_resume_ctrl", 32'(ctrl_vec), 32'(C_FL));
        next_cycle();
        #1;
        check("fl_done_state", 32'(ctrl_state), 32'd0);
        check("fl_stall", 32'(stall_cycles), 32'd12);

        // Forwarding priority and x0 exclusion.
        mem_writeEnable = 1'b1; mem_writeSelect = 5'd7;
        wb_writeEnable = 1'b1;  wb_writeSelect = 5'd7;
        ex_aLoc = 5'd7; ex_bLoc = 5'd3;
        #1;
        check("fwdA_exmem", 32'(fwdA_sel), 32'd1);
        check("fwdB_none", 32'(fwdB_sel), 32'd0);
        mem_writeEnable = 1'b0; ex_bLoc = 5'd7;
        #1;
        check("fwdA_memwb", 32'(fwdA_sel), 32'd2);
        check("fwdB_memwb", 32'(fwdB_sel), 32'd2);
        mem_writeEnable = 1'b1; mem_writeSelect = 5'd0; wb_writeSelect = 5'd0;
        ex_aLoc = 5'd0;
        #1;
        check("fwdA_x0", 32'(fwdA_sel), 32'd0);

        // Asynchronous reset in the middle of MEM_WAIT.
        next_cycle();
        idle();
        mem_req = 1'b1;
        mem_writeEnable = 1'b1; mem_writeSelect = 5'd4; ex_aLoc = 5'd4;
        next_cycle();
        mem_ready = 1'b1;
        #1;
        check("ar_pre_state", 32'(ctrl_state), 32'd1);
        check("ar_pre_ctrl", 32'(ctrl_vec), 32'(C_RUN));
        check("ar_pre_fwd", 32'(fwdA_sel), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_ctrl", 32'(ctrl_vec), 32'(C_ZERO));
        check("ar_state", 32'(ctrl_state), 32'd0);
        check("ar_stall", 32'(stall_cycles), 32'd0);
        check("ar_fwd", 32'(fwdA_sel), 32'd0);

        // Saturation of the stall counter under a long freeze.
        next_cycle();
        idle();
        mem_req = 1'b1;
        reset = 1'b0;
        repeat (65534) @(negedge clk);
        #1;
        check("sat_fffe", 32'(stall_cycles), 32'h0000fffe);
        next_cycle();
        #1;
        check("sat_ffff", 32'(stall_cycles), 32'h0000ffff);
        repeat (3) @(negedge clk);
        #1;
        check("sat_hold", 32'(stall_cycles), 32'h0000ffff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
